// File: rtl/stq_pkg.sv
// Shared types for the store queue: instruction/writeback formats, queue entry and head FSM states.
package stq_pkg;

  localparam int DEFAULT_STQ_DEPTH = 5;
  localparam int TAG_WIDTH         = 6;
  localparam int PIPE_WIDTH        = 5;

  typedef struct packed {
    logic [TAG_WIDTH-1:0] tag;
    logic                 rdy;
    logic [31:0]          data;
  } operand_t;

  typedef struct packed {
    logic [6:0]           opcode;
    logic [TAG_WIDTH-1:0] dest_tag;
    operand_t             src_0_a;
    operand_t             src_1_b;
    logic                 agu_comp;
  } instruction_t;

  typedef struct packed {
    logic                 is_valid;
    logic [TAG_WIDTH-1:0] dest_tag;
    logic [31:0]          result;
    logic                 exception;
  } writeback_packet_t;

  typedef struct packed {
    logic         valid;
    logic         addr_rdy;
    logic         data_rdy;
    instruction_t inst;
  } stq_entry_t;

  typedef enum logic [1:0] {H_IDLE, H_REQ, H_DONE} stq_head_state_t;

endpackage

// File: rtl/stq_ptr.sv
// Wrapping pointer increment for a circular buffer whose depth need not be a power of two.
module stq_ptr
  import stq_pkg::*;
#(
  parameter int DEPTH = DEFAULT_STQ_DEPTH,
  parameter int W     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic [W-1:0] ptr_i,
  output logic [W-1:0] next_o
);

  assign next_o = (ptr_i == W'(DEPTH - 1)) ? '0 : ptr_i + W'(1);

endmodule

// File: rtl/stq.sv
// Store queue: allocates stores in order, snoops CDB/AGU for data and address, exports resolved
// stores for load forwarding and drains the ROB-head store to the data cache.
module stq
  import stq_pkg::*;
#(
  parameter int STQ_DEPTH = DEFAULT_STQ_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              cache_stall,
  input  instruction_t      stq_entry,
  input  logic              stq_we,
  output logic              stq_write_rdy,
  input  writeback_packet_t cdb_ports [PIPE_WIDTH],
  input  writeback_packet_t agu_port,
  input  logic [TAG_WIDTH-1:0] rob_head,
  output instruction_t      store_q [STQ_DEPTH],
  output logic              mem_req_valid,
  input  logic              mem_req_rdy,
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_wdata,
  output writeback_packet_t store_wb_pkt
);

  localparam int PTR_W = (STQ_DEPTH > 1) ? $clog2(STQ_DEPTH) : 1;
  localparam int CNT_W = $clog2(STQ_DEPTH + 1);

  stq_entry_t        entries_q [STQ_DEPTH];
  stq_entry_t        entries_d [STQ_DEPTH];
  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [PTR_W-1:0]  headNext, tailNext;
  logic [CNT_W-1:0]  count_q, count_d;
  stq_head_state_t   state_q;
  logic              mem_req_valid_q;
  logic [31:0]       mem_addr_q, mem_wdata_q;
  writeback_packet_t store_wb_pkt_q;

  logic       alloc, pop, keepHead, headReady;
  stq_entry_t headEntry;

  stq_ptr #(.DEPTH(STQ_DEPTH), .W(PTR_W)) u_head_ptr (.ptr_i(head_q), .next_o(headNext));
  stq_ptr #(.DEPTH(STQ_DEPTH), .W(PTR_W)) u_tail_ptr (.ptr_i(tail_q), .next_o(tailNext));

  assign stq_write_rdy = (count_q != CNT_W'(STQ_DEPTH));
  assign alloc         = stq_we && stq_write_rdy && !flush;
  assign pop           = (state_q == H_DONE);
  assign keepHead      = (state_q != H_IDLE);
  assign headEntry     = entries_q[head_q];
  assign headReady     = headEntry.valid && headEntry.addr_rdy && headEntry.data_rdy &&
                         (headEntry.inst.dest_tag == rob_head);

  // A store being drained is the ROB head and survives a flush; a pop still completes on top of it.
  always_comb begin
    entries_d = entries_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    if (flush) begin
      for (int i = 0; i < STQ_DEPTH; i++) begin
        if (!(keepHead && (PTR_W'(i) == head_q))) entries_d[i] = '0;
      end
      if (keepHead) begin
        tail_d  = headNext;
        count_d = CNT_W'(1);
      end else begin
        head_d  = '0;
        tail_d  = '0;
        count_d = '0;
      end
    end else begin
      if (alloc) begin
        entries_d[tail_q].valid    = 1'b1;
        entries_d[tail_q].addr_rdy = 1'b0;
        entries_d[tail_q].data_rdy = stq_entry.src_1_b.rdy;
        entries_d[tail_q].inst     = stq_entry;
        tail_d                     = tailNext;
      end
      for (int i = 0; i < STQ_DEPTH; i++) begin
        if (entries_d[i].valid) begin
          if (!entries_d[i].data_rdy) begin
            for (int p = 0; p < PIPE_WIDTH; p++) begin
              if (cdb_ports[p].is_valid &&
                  (cdb_ports[p].dest_tag == entries_d[i].inst.src_1_b.tag)) begin
                entries_d[i].inst.src_1_b.data = cdb_ports[p].result;
                entries_d[i].data_rdy          = 1'b1;
              end
            end
          end
          if (agu_port.is_valid && (agu_port.dest_tag == entries_d[i].inst.dest_tag)) begin
            entries_d[i].inst.src_0_a.data = agu_port.result;
            entries_d[i].inst.agu_comp     = 1'b1;
            entries_d[i].addr_rdy          = 1'b1;
          end
        end
      end
      count_d = count_q + CNT_W'(alloc);
    end
    if (pop) begin
      entries_d[head_q] = '0;
      head_d            = headNext;
      count_d           = count_d - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STQ_DEPTH; i++) entries_q[i] <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      entries_q <= entries_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
    end
  end

  // Head drain: request held stable until accepted, completion pulse issued on leaving H_DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= H_IDLE;
      mem_req_valid_q <= 1'b0;
      mem_addr_q      <= '0;
      mem_wdata_q     <= '0;
      store_wb_pkt_q  <= '0;
    end else begin
      store_wb_pkt_q <= '0;
      case (state_q)
        H_IDLE: begin
          if (!flush && headReady) begin
            state_q         <= H_REQ;
            mem_req_valid_q <= 1'b1;
            mem_addr_q      <= headEntry.inst.src_0_a.data;
            mem_wdata_q     <= headEntry.inst.src_1_b.data;
          end
        end
        H_REQ: begin
          if (mem_req_rdy && !cache_stall) begin
            state_q         <= H_DONE;
            mem_req_valid_q <= 1'b0;
          end
        end
        H_DONE: begin
          state_q                 <= H_IDLE;
          store_wb_pkt_q.is_valid <= 1'b1;
          store_wb_pkt_q.dest_tag <= headEntry.inst.dest_tag;
        end
        default: state_q <= H_IDLE;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < STQ_DEPTH; i++) begin
      store_q[i] = (entries_q[i].valid && entries_q[i].addr_rdy && entries_q[i].data_rdy)
                   ? entries_q[i].inst : '0;
    end
  end

  assign mem_req_valid = mem_req_valid_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign store_wb_pkt  = store_wb_pkt_q;

endmodule

// File: tb/tb_stq.sv
// Directed bench for the store queue with a scoreboard of expected cache requests and completions.
module tb_stq;
  import stq_pkg::*;

  localparam int DEPTH = DEFAULT_STQ_DEPTH;

  typedef struct {
    logic [TAG_WIDTH-1:0] tag;
    logic [31:0]          addr;
    logic [31:0]          data;
  } expReq_t;

  logic                 clk = 1'b0;
  logic                 rst, flush, cache_stall, stq_we, stq_write_rdy, mem_req_rdy, mem_req_valid;
  instruction_t         stq_entry;
  writeback_packet_t    cdb_ports [PIPE_WIDTH];
  writeback_packet_t    agu_port, store_wb_pkt;
  logic [TAG_WIDTH-1:0] rob_head;
  instruction_t         store_q [DEPTH];
  logic [31:0]          mem_addr, mem_wdata;

  int      testsRun = 0;
  int      testsFailed = 0;
  expReq_t expQ[$];
  expReq_t cur;

  stq #(.STQ_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush), .cache_stall(cache_stall),
    .stq_entry(stq_entry), .stq_we(stq_we), .stq_write_rdy(stq_write_rdy),
    .cdb_ports(cdb_ports), .agu_port(agu_port), .rob_head(rob_head),
    .store_q(store_q), .mem_req_valid(mem_req_valid), .mem_req_rdy(mem_req_rdy),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .store_wb_pkt(store_wb_pkt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic instruction_t makeStore(input logic [TAG_WIDTH-1:0] tag, input logic [TAG_WIDTH-1:0] srcTag,
                                             input logic srcRdy, input logic [31:0] srcData);
    instruction_t s;
    s = '0;
    s.opcode          = 7'h23;
    s.dest_tag        = tag;
    s.src_1_b.tag     = srcTag;
    s.src_1_b.rdy     = srcRdy;
    s.src_1_b.data    = srcData;
    return s;
  endfunction

  function automatic int resolvedCount();
    int n = 0;
    for (int i = 0; i < DEPTH; i++) if (store_q[i] !== '0) n++;
    return n;
  endfunction

  function automatic logic [TAG_WIDTH-1:0] firstResolvedTag();
    for (int i = 0; i < DEPTH; i++) if (store_q[i] !== '0) return store_q[i].dest_tag;
    return '0;
  endfunction

  // One clock of stimulus; CDB and AGU strobes are pulses.
  task automatic applyStimulus(input logic we, input instruction_t entry,
                               input logic aguV, input logic [TAG_WIDTH-1:0] aguTag, input logic [31:0] aguRes,
                               input logic cdbV, input int cdbPort, input logic [TAG_WIDTH-1:0] cdbTag,
                               input logic [31:0] cdbRes);
    stq_we    = we;
    stq_entry = entry;
    agu_port  = '{is_valid: aguV, dest_tag: aguTag, result: aguRes, exception: 1'b0};
    cdb_ports[cdbPort] = '{is_valid: cdbV, dest_tag: cdbTag, result: cdbRes, exception: 1'b0};
    tick();
    stq_we   = 1'b0;
    agu_port = '0;
    cdb_ports[cdbPort] = '0;
  endtask

  task automatic allocReady(input logic [TAG_WIDTH-1:0] tag, input logic [31:0] addr, input logic [31:0] data);
    expQ.push_back('{tag: tag, addr: addr, data: data});
    applyStimulus(1'b1, makeStore(tag, '0, 1'b1, data), 1'b1, tag, addr, 1'b0, 0, '0, '0);
  endtask

  task automatic waitReq(input string tag);
    int c = 0;
    while (mem_req_valid !== 1'b1 && c < 20) begin
      tick();
      c++;
    end
    checkOutput({tag, "_reqValid"}, 128'(mem_req_valid), 128'(1'b1));
    if (expQ.size() == 0) begin
      checkOutput({tag, "_scoreboardEmpty"}, 128'(0), 128'(1));
      cur = '{tag: '0, addr: '0, data: '0};
    end else begin
      cur = expQ.pop_front();
    end
    checkOutput({tag, "_addr"}, 128'(mem_addr), 128'(cur.addr));
    checkOutput({tag, "_data"}, 128'(mem_wdata), 128'(cur.data));
  endtask

  task automatic finishHead(input string tag);
    int c = 0;
    writeback_packet_t expPkt;
    expPkt = '{is_valid: 1'b1, dest_tag: cur.tag, result: 32'h0, exception: 1'b0};
    while (store_wb_pkt.is_valid !== 1'b1 && c < 20) begin
      tick();
      c++;
    end
    checkOutput({tag, "_wbPkt"}, 128'(store_wb_pkt), 128'(expPkt));
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; cache_stall = 1'b0; stq_we = 1'b0; mem_req_rdy = 1'b0;
    stq_entry = '0; agu_port = '0; rob_head = '0;
    for (int p = 0; p < PIPE_WIDTH; p++) cdb_ports[p] = '0;
    tick(); tick();
    rst = 1'b0;

    checkOutput("reset_writeRdy", 128'(stq_write_rdy), 128'(1'b1));
    checkOutput("reset_reqValid", 128'(mem_req_valid), 128'(1'b0));
    checkOutput("reset_wbPkt", 128'(store_wb_pkt), 128'(0));
    checkOutput("reset_storeQ", 128'(resolvedCount()), 128'(0));

    // Fill with write strobe held; the sixth write must be ignored.
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1'b1, makeStore(TAG_WIDTH'(1 + k), 6'd40, 1'b0, '0), 1'b0, '0, '0, 1'b0, 0, '0, '0);
      checkOutput($sformatf("fill_writeRdy_%0d", k), 128'(stq_write_rdy), 128'((k + 1) < DEPTH));
    end
    applyStimulus(1'b0, '0, 1'b1, 6'd1, 32'h3000, 1'b1, 4, 6'd40, 32'hBEEF);
    checkOutput("fill_q0Tag", 128'(store_q[0].dest_tag), 128'(6'd1));
    checkOutput("fill_q0Addr", 128'(store_q[0].src_0_a.data), 128'(32'h3000));
    checkOutput("fill_q0Data", 128'(store_q[0].src_1_b.data), 128'(32'hBEEF));
    applyStimulus(1'b0, '0, 1'b1, 6'd6, 32'h4444, 1'b0, 0, '0, '0);
    checkOutput("fill_sixthDropped", 128'(resolvedCount()), 128'(1));
    flush = 1'b1; tick(); flush = 1'b0;
    checkOutput("flushIdle_writeRdy", 128'(stq_write_rdy), 128'(1'b1));
    checkOutput("flushIdle_storeQ", 128'(resolvedCount()), 128'(0));

    // Tag 7 waits on tag 3; CDB and AGU resolve it in the same cycle.
    applyStimulus(1'b1, makeStore(6'd7, 6'd3, 1'b0, '0), 1'b0, '0, '0, 1'b0, 0, '0, '0);
    checkOutput("fwd_pending", 128'(store_q[0]), 128'(0));
    expQ.push_back('{tag: 6'd7, addr: 32'h1000, data: 32'hDEAD});
    applyStimulus(1'b0, '0, 1'b1, 6'd7, 32'h1000, 1'b1, 2, 6'd3, 32'hDEAD);
    checkOutput("fwd_addr", 128'(store_q[0].src_0_a.data), 128'(32'h1000));
    checkOutput("fwd_data", 128'(store_q[0].src_1_b.data), 128'(32'hDEAD));
    checkOutput("fwd_tag", 128'(store_q[0].dest_tag), 128'(6'd7));
    checkOutput("fwd_aguComp", 128'(store_q[0].agu_comp), 128'(1'b1));

    // Drain under back-pressure: request must hold steady.
    rob_head = 6'd7;
    waitReq("bp");
    for (int k = 0; k < 4; k++) begin
      tick();
      checkOutput($sformatf("bp_hold_valid_%0d", k), 128'(mem_req_valid), 128'(1'b1));
      checkOutput($sformatf("bp_hold_addr_%0d", k), 128'(mem_addr), 128'(cur.addr));
      checkOutput($sformatf("bp_hold_data_%0d", k), 128'(mem_wdata), 128'(cur.data));
    end
    mem_req_rdy = 1'b1;
    tick();
    checkOutput("bp_accepted", 128'(mem_req_valid), 128'(1'b0));
    checkOutput("bp_noEarlyWb", 128'(store_wb_pkt.is_valid), 128'(1'b0));
    tick();
    checkOutput("bp_wbPkt", 128'(store_wb_pkt), 128'({1'b1, 6'd7, 32'h0, 1'b0}));
    tick();
    checkOutput("bp_wbPulse", 128'(store_wb_pkt.is_valid), 128'(1'b0));
    checkOutput("bp_freed", 128'(resolvedCount()), 128'(0));

    // Seven sequential stores wrap the pointers; AGU write-in lands on the allocating cycle.
    for (int k = 0; k < 7; k++) begin
      rob_head = TAG_WIDTH'(10 + k);
      allocReady(TAG_WIDTH'(10 + k), 32'h2000 + 32'(4 * k), 32'h100 + 32'(k));
      waitReq($sformatf("wrap_%0d", k));
      finishHead($sformatf("wrap_%0d", k));
    end
    tick();

    // Flush while the head store is in flight keeps only that store.
    mem_req_rdy = 1'b0;
    rob_head    = 6'd20;
    allocReady(6'd20, 32'h5000, 32'hA0);
    allocReady(6'd21, 32'h5004, 32'hA1);
    allocReady(6'd22, 32'h5008, 32'hA2);
    waitReq("flushReq");
    expQ.delete();
    flush = 1'b1;
    applyStimulus(1'b1, makeStore(6'd30, '0, 1'b1, 32'hEE), 1'b1, 6'd30, 32'h6000, 1'b0, 0, '0, '0);
    flush = 1'b0;
    checkOutput("flushReq_reqHeld", 128'(mem_req_valid), 128'(1'b1));
    checkOutput("flushReq_survivors", 128'(resolvedCount()), 128'(1));
    checkOutput("flushReq_headTag", 128'(firstResolvedTag()), 128'(6'd20));
    mem_req_rdy = 1'b1;
    finishHead("flushReq");
    tick();
    checkOutput("flushReq_empty", 128'(resolvedCount()), 128'(0));
    for (int k = 0; k < DEPTH; k++) begin
      applyStimulus(1'b1, makeStore(TAG_WIDTH'(50 + k), 6'd41, 1'b0, '0), 1'b0, '0, '0, 1'b0, 0, '0, '0);
      checkOutput($sformatf("flushReq_count_%0d", k), 128'(stq_write_rdy), 128'((k + 1) < DEPTH));
    end
    rob_head = '0;
    flush = 1'b1; tick(); flush = 1'b0;

    // cache_stall overrides a ready cache.
    rob_head    = 6'd25;
    cache_stall = 1'b1;
    allocReady(6'd25, 32'h7000, 32'h77);
    waitReq("stall");
    for (int k = 0; k < 3; k++) begin
      tick();
      checkOutput($sformatf("stall_hold_%0d", k), 128'(mem_req_valid), 128'(1'b1));
    end
    cache_stall = 1'b0;
    finishHead("stall");
    tick();

    // Reset in the middle of a request.
    mem_req_rdy = 1'b0;
    rob_head    = 6'd26;
    allocReady(6'd26, 32'h8000, 32'h88);
    waitReq("rstMid");
    rst = 1'b1; tick(); rst = 1'b0;
    checkOutput("rstMid_reqDrop", 128'(mem_req_valid), 128'(1'b0));
    checkOutput("rstMid_writeRdy", 128'(stq_write_rdy), 128'(1'b1));
    checkOutput("rstMid_storeQ", 128'(resolvedCount()), 128'(0));

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
